// File: rtl/alu_mdu_if.sv
// Request/response bundle between the execute-stage control and the ALU/MDU.
// Also carries the flush/busy side signals.
interface alu_mdu_if #(
   parameter int WIDTH = 32
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       op;
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             busy;

   modport master (
      output flush, in_valid, op, srca, srcb, out_ready,
      input  in_ready, out_valid, result, zero, busy
   );

   modport slave (
      input  flush, in_valid, op, srca, srcb, out_ready,
      output in_ready, out_valid, result, zero, busy
   );
endinterface

// File: rtl/alu_mdu.sv
// RV32I ALU plus RV32M multiply/divide unit with a valid/ready handshake.
// Simple ops and multiplies finish in one cycle; divides use a radix-2 restoring loop.
module alu_mdu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic      clk,
   input logic      reset,
   alu_mdu_if.slave bus
);
   localparam logic [4:0] OP_ADD    = 5'd0;
   localparam logic [4:0] OP_SUB    = 5'd1;
   localparam logic [4:0] OP_SLL    = 5'd2;
   localparam logic [4:0] OP_SLT    = 5'd3;
   localparam logic [4:0] OP_SLTU   = 5'd4;
   localparam logic [4:0] OP_XOR    = 5'd5;
   localparam logic [4:0] OP_SRL    = 5'd6;
   localparam logic [4:0] OP_SRA    = 5'd7;
   localparam logic [4:0] OP_OR     = 5'd8;
   localparam logic [4:0] OP_AND    = 5'd9;
   localparam logic [4:0] OP_MUL    = 5'd10;
   localparam logic [4:0] OP_MULH   = 5'd11;
   localparam logic [4:0] OP_MULHSU = 5'd12;
   localparam logic [4:0] OP_MULHU  = 5'd13;
   localparam logic [4:0] OP_DIV    = 5'd14;
   localparam logic [4:0] OP_DIVU   = 5'd15;
   localparam logic [4:0] OP_REM    = 5'd16;
   localparam logic [4:0] OP_REMU   = 5'd17;

   localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ALL1    = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2} state_t;

   state_t             state_r, state_s;
   logic [WIDTH-1:0]   result_r, quo_r, rem_r, dvs_r;
   logic               zero_r, neg_q_r, neg_r_r, is_rem_r;
   logic [SHW-1:0]     cnt_r;

   logic               is_div_op_s, sgn_div_s, rem_op_s, quick_s;
   logic [SHW-1:0]     shamt_s;
   logic [WIDTH-1:0]   imm_s, abs_a_s, abs_b_s;
   logic [2*WIDTH-1:0] mul_a_s, mul_b_s, prod_s;
   logic [WIDTH:0]     sh_s, diff_s;
   logic               qbit_s;
   logic [WIDTH-1:0]   rem_nxt_s, quo_nxt_s, div_res_s;

   // Op decode, operand magnitudes and the one-cycle result path
   always_comb begin
      is_div_op_s = (bus.op >= OP_DIV) && (bus.op <= OP_REMU);
      sgn_div_s   = (bus.op == OP_DIV) || (bus.op == OP_REM);
      rem_op_s    = (bus.op == OP_REM) || (bus.op == OP_REMU);
      quick_s     = (bus.srcb == ZERO) ||
                    (sgn_div_s && (bus.srca == MIN_INT) && (bus.srcb == ALL1));
      shamt_s     = bus.srcb[SHW-1:0];
      abs_a_s     = (sgn_div_s && bus.srca[WIDTH-1]) ? (ZERO - bus.srca) : bus.srca;
      abs_b_s     = (sgn_div_s && bus.srcb[WIDTH-1]) ? (ZERO - bus.srcb) : bus.srcb;
      // MULHSU treats only srca as signed; sign-extending to 2*WIDTH gives exact products
      mul_a_s     = {{WIDTH{((bus.op == OP_MULH) || (bus.op == OP_MULHSU)) && bus.srca[WIDTH-1]}}, bus.srca};
      mul_b_s     = {{WIDTH{(bus.op == OP_MULH) && bus.srcb[WIDTH-1]}}, bus.srcb};
      prod_s      = mul_a_s * mul_b_s;
      imm_s       = ZERO;
      case (bus.op)
         OP_ADD:    imm_s = bus.srca + bus.srcb;
         OP_SUB:    imm_s = bus.srca - bus.srcb;
         OP_SLL:    imm_s = bus.srca << shamt_s;
         OP_SLT:    imm_s = {{(WIDTH-1){1'b0}}, ($signed(bus.srca) < $signed(bus.srcb))};
         OP_SLTU:   imm_s = {{(WIDTH-1){1'b0}}, (bus.srca < bus.srcb)};
         OP_XOR:    imm_s = bus.srca ^ bus.srcb;
         OP_SRL:    imm_s = bus.srca >> shamt_s;
         OP_SRA:    imm_s = $unsigned($signed(bus.srca) >>> shamt_s);
         OP_OR:     imm_s = bus.srca | bus.srcb;
         OP_AND:    imm_s = bus.srca & bus.srcb;
         OP_MUL:    imm_s = prod_s[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:
                    imm_s = prod_s[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:
                    imm_s = (bus.srcb == ZERO) ? ALL1 : MIN_INT;
         OP_REM, OP_REMU:
                    imm_s = (bus.srcb == ZERO) ? bus.srca : ZERO;
         default:   imm_s = ZERO;
      endcase
   end

   // One restoring shift-subtract step plus the final sign fix-up
   always_comb begin
      sh_s      = {rem_r, quo_r[WIDTH-1]};
      diff_s    = sh_s - {1'b0, dvs_r};
      qbit_s    = ~diff_s[WIDTH];
      rem_nxt_s = qbit_s ? diff_s[WIDTH-1:0] : sh_s[WIDTH-1:0];
      quo_nxt_s = {quo_r[WIDTH-2:0], qbit_s};
      if (is_rem_r) begin
         div_res_s = neg_r_r ? (ZERO - rem_nxt_s) : rem_nxt_s;
      end else begin
         div_res_s = neg_q_r ? (ZERO - quo_nxt_s) : quo_nxt_s;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; flush wins over accept and over out_ready
   always_comb begin
      state_s = state_r;
      if (bus.flush) begin
         state_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (!bus.in_valid) begin
                  state_s = S_IDLE;
               end else if (is_div_op_s && !quick_s) begin
                  state_s = S_DIV;
               end else begin
                  state_s = S_DONE;
               end
            end
            S_DIV: begin
               if (cnt_r == {SHW{1'b0}}) begin
                  state_s = S_DONE;
               end else begin
                  state_s = S_DIV;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  state_s = S_IDLE;
               end else begin
                  state_s = S_DONE;
               end
            end
            default: state_s = S_IDLE;
         endcase
      end
   end

   // Handshake outputs decoded from the state register
   always_comb begin
      bus.in_ready  = (state_r == S_IDLE);
      bus.out_valid = (state_r == S_DONE);
      bus.busy      = (state_r != S_IDLE);
   end

   // Datapath registers; frozen during flush and outside accept/divide cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         result_r <= ZERO;
         zero_r   <= 1'b1;
         quo_r    <= ZERO;
         rem_r    <= ZERO;
         dvs_r    <= ZERO;
         cnt_r    <= {SHW{1'b0}};
         neg_q_r  <= 1'b0;
         neg_r_r  <= 1'b0;
         is_rem_r <= 1'b0;
      end else if (!bus.flush) begin
         case (state_r)
            S_IDLE: begin
               if (bus.in_valid && is_div_op_s && !quick_s) begin
                  quo_r    <= abs_a_s;
                  dvs_r    <= abs_b_s;
                  rem_r    <= ZERO;
                  cnt_r    <= SHW'(WIDTH-1);
                  neg_q_r  <= sgn_div_s && (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
                  neg_r_r  <= sgn_div_s && bus.srca[WIDTH-1];
                  is_rem_r <= rem_op_s;
               end else if (bus.in_valid) begin
                  result_r <= imm_s;
                  zero_r   <= (imm_s == ZERO);
               end
            end
            S_DIV: begin
               quo_r <= quo_nxt_s;
               rem_r <= rem_nxt_s;
               cnt_r <= cnt_r - SHW'(1);
               if (cnt_r == {SHW{1'b0}}) begin
                  result_r <= div_res_s;
                  zero_r   <= (div_res_s == ZERO);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.result = result_r;
   assign bus.zero   = zero_r;
endmodule

// File: tb/tb_alu_mdu.sv
// Directed-vector bench for alu_mdu at WIDTH=32 with hand-computed expectations.
module tb_alu_mdu;
   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [31:0] last_res;

   alu_mdu_if #(.WIDTH(32)) bus ();

   alu_mdu #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one op for a single edge; returns just after that edge
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.srca     = a;
      bus.srcb     = b;
      tick();
      bus.in_valid = 1'b0;
      bus.srca     = 32'hDEAD_BEEF;
      bus.srcb     = 32'h0BAD_F00D;
   endtask

   task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat;
      int bad;
      lat = 1;
      bad = 0;
      issue(op, a, b);
      while (!bus.out_valid && lat < 100) begin
         if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) bad++;
         tick();
         lat++;
      end
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_res"}, bus.result, exp);
      chk({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, exp == 32'd0});
      if (exp_lat > 1) chk({tag, "_busy"}, bad, 32'd0);
      last_res = exp;
      tick();
   endtask

   initial begin
      int bad;
      checks       = 0;
      errors       = 0;
      last_res     = 32'd0;
      reset        = 1'b1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      bus.op       = 5'd0;
      bus.srca     = 32'd0;
      bus.srcb     = 32'd0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_result", bus.result, 32'd0);
      chk("rst_zero", {31'd0, bus.zero}, 32'd1);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);

      run("add",    5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1);
      run("sub",    5'd1,  32'd5,         32'd5,         32'd0,         1);
      run("sll",    5'd2,  32'h0000_0003, 32'h0000_0024, 32'h0000_0030, 1);
      run("slt",    5'd3,  32'hFFFF_FFFF, 32'h0000_0001, 32'd1,         1);
      run("sltu",   5'd4,  32'h0000_0001, 32'hFFFF_FFFF, 32'd1,         1);
      run("xor",    5'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
      run("srl",    5'd6,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1);
      run("sra",    5'd7,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1);
      run("or",     5'd8,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1);
      run("and",    5'd9,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1);
      run("illegal",5'd25, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0,         1);
      run("mul",    5'd10, 32'h0001_0000, 32'h0001_0000, 32'd0,         1);
      run("mulh",   5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1);
      run("mulhsu", 5'd12, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1);
      run("mulhu",  5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
      run("div",    5'd14, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
      run("rem",    5'd16, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
      run("divu",   5'd15, 32'd100,       32'd7,         32'd14,        33);
      run("remu",   5'd17, 32'd100,       32'd7,         32'd2,         33);
      run("divu_z", 5'd15, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      run("rem_z",  5'd16, 32'd5,         32'd0,         32'd5,         1);
      run("div_ov", 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run("rem_ov", 5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

      // Backpressure: result held, new request ignored while DONE
      bus.out_ready = 1'b0;
      issue(5'd0, 32'd3, 32'd4);
      chk("bp_valid0", {31'd0, bus.out_valid}, 32'd1);
      bad = 0;
      bus.in_valid = 1'b1;
      bus.op       = 5'd0;
      bus.srca     = 32'd9;
      bus.srcb     = 32'd9;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.result !== 32'd7 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
      end
      bus.in_valid = 1'b0;
      chk("bp_hold", bad, 32'd0);
      bus.out_ready = 1'b1;
      tick();
      chk("bp_idle_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("bp_idle_valid", {31'd0, bus.out_valid}, 32'd0);
      last_res = 32'd7;

      // Accept coincident with flush is dropped
      bus.flush = 1'b1;
      issue(5'd0, 32'd1, 32'd1);
      bus.flush = 1'b0;
      chk("fl_drop_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("fl_drop_res", bus.result, last_res);

      // Flush at cycle 10 of a divide
      issue(5'd15, 32'd1000, 32'd3);
      repeat (9) tick();
      chk("fl_mid_busy", {31'd0, bus.busy}, 32'd1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("fl_idle", {31'd0, bus.in_ready}, 32'd1);
      chk("fl_res", bus.result, last_res);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
         tick();
      end
      chk("fl_no_valid", bad, 32'd0);
      run("fl_add", 5'd0, 32'd1, 32'd1, 32'd2, 1);

      // Reset mid-divide
      issue(5'd15, 32'd1000, 32'd3);
      repeat (9) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rs_result", bus.result, 32'd0);
      chk("rs_zero", {31'd0, bus.zero}, 32'd1);
      chk("rs_ready", {31'd0, bus.in_ready}, 32'd1);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
         tick();
      end
      chk("rs_no_valid", bad, 32'd0);
      run("rs_add", 5'd0, 32'd1, 32'd1, 32'd2, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised successor to the core's single-cycle ALU. It executes the full RV32I integer ALU op set plus the RV32M multiply/divide/remainder ops behind a valid/ready handshake, with a registered result.
- Simple ops and multiplies return one cycle after acceptance.
- Divide and remainder run an iterative radix-2 restoring loop.
- Sits in the execute stage. The control unit stalls the pipeline while in_ready or out_valid is low.

Parameters:
WIDTH, 32, datapath width; power of two, 8 or greater.
SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  abort any in-flight op; synchronous
in_valid  in  1  operands/op presented
in_ready  out  1  unit can accept an op this cycle
op  in  5  operation select (encoding below)
srca  in  WIDTH  operand A / dividend
srcb  in  WIDTH  operand B / divisor / shift amount
out_valid  out  1  result holds a completed op
out_ready  in  1  consumer takes result this cycle
result  out  WIDTH  registered result
zero  out  1  registered (result == 0)
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port name reset.
- Op encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU
  - 18..31 are illegal: complete like a simple op with result 0.
- Arithmetic rules:
  - Shifts use srcb[SHW-1:0] only. SRA sign-extends.
  - SLT/SLTU produce 1 or 0, zero-extended.
  - MUL returns the low WIDTH bits of the 2*WIDTH product. MULH*/MULHU return the high WIDTH bits, with signedness per RISC-V (MULHSU: srca signed, srcb unsigned).
  - Adds/subs wrap modulo 2^WIDTH.
- States: IDLE, DIV, DONE.
- Handshake:
  - in_ready = (state==IDLE).
  - Accept = in_valid & in_ready. The op and operands are captured at the accept edge.
  - out_valid = (state==DONE).
  - result and zero stay stable while out_valid=1 and out_ready=0.
  - Leaving DONE requires out_ready=1; the next state is IDLE. There is no accept in the same cycle: one bubble per op, by design.
- Transitions:
  - IDLE + accept of a simple op (0..13, illegal) → DONE. Result is registered that edge, so latency is 1.
  - IDLE + accept of DIV/DIVU/REM/REMU:
    - divisor == 0 → DONE at latency 1. Quotient is all ones; remainder is the dividend.
    - signed op with srca == MIN_INT and srcb == all-ones → DONE at latency 1. Quotient is MIN_INT; remainder is 0.
    - otherwise → DIV. Load operand magnitudes, clear the remainder register, set the bit counter to WIDTH-1.
  - DIV: each cycle does one shift-subtract step and decrements the counter. At counter == 0 it applies the sign fix-up (quotient negated if the operand signs differ; remainder takes the dividend's sign) and goes to DONE.
  - Total divide latency: out_valid asserts WIDTH+1 cycles after the accept edge.
- flush:
  - Any state → IDLE on the next edge. out_valid=0, and the result register is unchanged.
  - flush has priority over accept and over out_ready.
  - in_ready is 0 in the flush cycle unless already IDLE. An accept coincident with flush is dropped.
- Reset: state=IDLE, result=0, zero=1, out_valid=0, in_ready=1 (after the reset edge), busy=0. Reset mid-divide abandons the op.
- zero is computed from the final result value when it is written, never from the intermediate divide registers.
- Operand inputs are don't-care when not accepted. Internal registers must not change on in_valid when in_ready=0.

Test Plan:
- Simple ops, WIDTH=32, out_ready=1:
  - ADD 0x7FFFFFFF+1 → 0x80000000, zero=0, out_valid exactly 1 cycle after accept.
  - SUB 5-5 → 0, zero=1.
  - SRA 0x80000000 by srcb=0x21 → 0xC0000000 (shift uses low 5 bits, i.e. 1).
  - SLTU 1 vs 0xFFFFFFFF → 1.
  - op=25 → 0.
- Multiplies:
  - MULH 0xFFFFFFFF × 0xFFFFFFFF → 0.
  - MULHU same operands → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
  - MUL 0x10000 × 0x10000 → 0.
- Divide timing and signs:
  - DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14.
  - out_valid rises exactly 33 cycles after accept; busy=1 throughout; in_ready=0 throughout.
- Divide corner cases, each with latency 1:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after ADD 3+4. result stays 7, out_valid stays 1, in_ready stays 0.
  - Raise out_ready. The next cycle is IDLE and in_ready=1.
- Abort paths:
  - flush at cycle 10 of a DIVU → IDLE next edge, no out_valid. A following ADD 1+1 returns 2 at latency 1.
  - Repeat with reset instead of flush → outputs return to reset values (result=0, zero=1).
